// File: rtl/reg_file_pkg.sv
// Shared constants and address-validity helper for the parametrised register file.
package reg_file_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 8;
    localparam int unsigned DefAddrW = 3;

    // An address is usable if it maps to a real register that is not the hardwired zero.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth,
                                        input bit zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Write/read port bundle for param_register_file.
interface param_register_file_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr0;
    logic [WIDTH-1:0]  rdata0;
    logic [ADDR_W-1:0] raddr1;
    logic [WIDTH-1:0]  rdata1;
    logic              wr_err;

    modport master (
        output we, waddr, wdata, raddr0, raddr1,
        input  rdata0, rdata1, wr_err
    );

    modport slave (
        input  we, waddr, wdata, raddr0, raddr1,
        output rdata0, rdata1, wr_err
    );
endinterface

// File: rtl/reg_cell.sv
// Single WIDTH-bit storage register with load enable and synchronous reset value.
module reg_cell #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/param_register_file.sv
// DEPTH x WIDTH register bank: one synchronous write port, two combinational read ports,
// optional write-to-read bypass and optional hardwired-zero register 0.
module param_register_file
    import reg_file_pkg::*;
#(
    parameter int unsigned      WIDTH     = DefWidth,
    parameter int unsigned      DEPTH     = DefDepth,
    parameter int unsigned      ADDR_W    = DefAddrW,
    parameter bit               ZERO_REG  = 1'b0,
    parameter bit               BYPASS    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                 clk,
    input logic                 rst,
    param_register_file_if.slave bus
);
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] cell_en;
    logic             wr_ok;
    logic             wr_en;
    logic             wr_err_q;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;

    assign wr_ok = addr_valid(32'(bus.waddr), DEPTH, ZERO_REG);
    assign wr_en = bus.we && !rst && wr_ok;

    always_comb begin
        cell_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cell_en[i] = wr_en && (bus.waddr == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_cell #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .en (cell_en[g]),
            .d  (bus.wdata),
            .q  (regs[g])
        );
    end

    // Invalid or hardwired-zero addresses read as 0; bypass overrides storage when enabled.
    always_comb begin
        rdata0 = '0;
        rdata1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr0 == ADDR_W'(i)) rdata0 = regs[i];
            if (bus.raddr1 == ADDR_W'(i)) rdata1 = regs[i];
        end
        if (!addr_valid(32'(bus.raddr0), DEPTH, ZERO_REG)) rdata0 = '0;
        if (!addr_valid(32'(bus.raddr1), DEPTH, ZERO_REG)) rdata1 = '0;
        if (BYPASS && wr_en && (bus.raddr0 == bus.waddr)) rdata0 = bus.wdata;
        if (BYPASS && wr_en && (bus.raddr1 == bus.waddr)) rdata1 = bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.we && !wr_ok;
        end
    end

    assign bus.rdata0 = rdata0;
    assign bus.rdata1 = rdata1;
    assign bus.wr_err = wr_err_q;
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: table-driven vectors on a default instance, hand sequences on a
// DEPTH=6 / ZERO_REG / no-bypass / RESET_VAL=0F instance.
module tb_param_register_file;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    param_register_file_if #(.WIDTH(8), .ADDR_W(3)) bus_a ();
    param_register_file_if #(.WIDTH(8), .ADDR_W(3)) bus_b ();

    param_register_file #(
        .WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1), .RESET_VAL(8'h00)
    ) dut_a (
        .clk(clk),
        .rst(rst_a),
        .bus(bus_a)
    );

    param_register_file #(
        .WIDTH(8), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0), .RESET_VAL(8'h0F)
    ) dut_b (
        .clk(clk),
        .rst(rst_b),
        .bus(bus_b)
    );

    typedef struct {
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] raddr0;
        logic [2:0] raddr1;
        logic [7:0] exp0;
        logic [7:0] exp1;
        logic       experr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the negedge, then compare just before the next rising edge.
    task automatic apply(input bit sel, input string tag, input bit chk, input logic r,
                         input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra0, input logic [2:0] ra1,
                         input logic [7:0] e0, input logic [7:0] e1, input logic eerr);
        @(negedge clk);
        if (sel) begin
            rst_b = r; bus_b.we = we; bus_b.waddr = wa; bus_b.wdata = wd;
            bus_b.raddr0 = ra0; bus_b.raddr1 = ra1;
        end else begin
            rst_a = r; bus_a.we = we; bus_a.waddr = wa; bus_a.wdata = wd;
            bus_a.raddr0 = ra0; bus_a.raddr1 = ra1;
        end
        #2;
        if (chk) begin
            if (sel) begin
                check({tag, " rdata0"}, bus_b.rdata0, e0);
                check({tag, " rdata1"}, bus_b.rdata1, e1);
                check({tag, " wr_err"}, 8'(bus_b.wr_err), 8'(eerr));
            end else begin
                check({tag, " rdata0"}, bus_a.rdata0, e0);
                check({tag, " rdata1"}, bus_a.rdata1, e1);
                check({tag, " wr_err"}, 8'(bus_a.wr_err), 8'(eerr));
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.we = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.raddr0 = '0; bus_a.raddr1 = '0;
        bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.raddr0 = '0; bus_b.raddr1 = '0;

        //        we  wa    wd     r0    r1    exp0   exp1   err
        vecs[0]  = '{1'b1, 3'd1, 8'hFF, 3'd1, 3'd2, 8'hFF, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 3'd2, 8'h99, 3'd1, 3'd2, 8'hFF, 8'h99, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 8'hFF, 8'h99, 1'b0};
        vecs[3]  = '{1'b1, 3'd5, 8'h11, 3'd0, 3'd3, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 3'd5, 8'h5A, 3'd5, 3'd5, 8'h5A, 8'h5A, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd1, 8'h5A, 8'hFF, 1'b0};
        vecs[6]  = '{1'b1, 3'd7, 8'h80, 3'd7, 3'd6, 8'h80, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 3'd0, 8'hC3, 3'd0, 3'd7, 8'hC3, 8'h80, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'hC3, 8'hC3, 1'b0};
        vecs[9]  = '{1'b1, 3'd6, 8'h01, 3'd5, 3'd2, 8'h5A, 8'h99, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 8'h01, 8'h80, 1'b0};

        // Instance A: reset held 2 cycles with a write pending, which must be dropped.
        apply(0, "a_rst0", 0, 1, 1, 3'd3, 8'hAA, 3'd3, 3'd3, 8'h00, 8'h00, 0);
        apply(0, "a_rst1", 1, 1, 1, 3'd3, 8'hAA, 3'd3, 3'd3, 8'h00, 8'h00, 0);
        apply(0, "a_post", 1, 0, 0, 3'd0, 8'h00, 3'd3, 3'd0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 11; i++) begin
            apply(0, $sformatf("a_vec%0d", i), 1, 0, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].raddr0, vecs[i].raddr1, vecs[i].exp0, vecs[i].exp1, vecs[i].experr);
        end

        // Instance A: reset with a write in flight clears everything.
        apply(0, "a_mid_rst", 0, 1, 1, 3'd4, 8'h3C, 3'd0, 3'd0, 8'h00, 8'h00, 0);
        apply(0, "a_mid_chk", 1, 0, 0, 3'd0, 8'h00, 3'd4, 3'd1, 8'h00, 8'h00, 0);

        // Instance B: reset to 0F, register 0 hardwired to zero.
        apply(1, "b_rst0", 0, 1, 0, 3'd0, 8'h00, 3'd0, 3'd1, 8'h00, 8'h0F, 0);
        apply(1, "b_rst1", 1, 1, 0, 3'd0, 8'h00, 3'd0, 3'd1, 8'h00, 8'h0F, 0);
        // No bypass: old value until the edge.
        apply(1, "b_w5a", 1, 0, 1, 3'd5, 8'h11, 3'd5, 3'd5, 8'h0F, 8'h0F, 0);
        apply(1, "b_w5b", 1, 0, 1, 3'd5, 8'h5A, 3'd5, 3'd5, 8'h11, 8'h11, 0);
        apply(1, "b_r5", 1, 0, 0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h5A, 8'h5A, 0);
        // Write to hardwired zero.
        apply(1, "b_wz", 1, 0, 1, 3'd0, 8'hC3, 3'd0, 3'd0, 8'h00, 8'h00, 0);
        apply(1, "b_wz_err", 1, 0, 0, 3'd0, 8'h00, 3'd0, 3'd1, 8'h00, 8'h0F, 1);
        apply(1, "b_wz_clr", 1, 0, 0, 3'd0, 8'h00, 3'd0, 3'd5, 8'h00, 8'h5A, 0);
        // Out-of-range write to 7 with DEPTH=6.
        apply(1, "b_oor", 1, 0, 1, 3'd7, 8'h77, 3'd7, 3'd5, 8'h00, 8'h5A, 0);
        apply(1, "b_oor_err", 1, 0, 0, 3'd0, 8'h00, 3'd7, 3'd5, 8'h00, 8'h5A, 1);
        apply(1, "b_oor_clr", 1, 0, 0, 3'd0, 8'h00, 3'd6, 3'd4, 8'h00, 8'h0F, 0);
        // Write 3C to reg 4, then reset mid-sequence with another write pending.
        apply(1, "b_w4", 1, 0, 1, 3'd4, 8'h3C, 3'd4, 3'd3, 8'h0F, 8'h0F, 0);
        apply(1, "b_r4", 1, 0, 0, 3'd0, 8'h00, 3'd4, 3'd3, 8'h3C, 8'h0F, 0);
        apply(1, "b_mid_oor", 0, 0, 1, 3'd6, 8'h55, 3'd4, 3'd3, 8'h3C, 8'h0F, 0);
        apply(1, "b_mid_rst", 1, 1, 1, 3'd3, 8'h55, 3'd4, 3'd3, 8'h3C, 8'h0F, 1);
        apply(1, "b_mid_chk", 1, 0, 0, 3'd0, 8'h00, 3'd4, 3'd3, 8'h0F, 8'h0F, 0);
        apply(1, "b_mid_chk2", 1, 0, 0, 3'd0, 8'h00, 3'd1, 3'd0, 8'h0F, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
